// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed 4-digit hex display scanner.
// A prescaler paces the digit index; new values are staged in a one-entry
// buffer and only promoted to the displayed register at a frame boundary,
// so a frame never shows a mix of old and new digits.
module hex_scan_driver #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        blank_lz,
    output logic [3:0]  digit_nibble,
    output logic [3:0]  digit_sel,
    output logic        digit_blank,
    output logic        frame_start
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   pend;
    logic [15:0]   disp;
    logic          blank_q;
    logic          tick;
    logic          wrap;
    logic          load_pend;
    logic          load_disp;
    logic [15:0]   upper;

    assign tick = (cnt == CW'(PRESCALE - 1));
    // Frame boundary: the tick that takes the index from 3 back to 0.
    assign wrap = tick && (idx == 2'd3);

    // Prescaler and digit index; the index moves only on a tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) idx <= idx + 2'd1;
        end
    end

    // Update FSM next-state: accept when empty, release to display on wrap.
    always_comb begin
        state_d   = state;
        load_pend = 1'b0;
        load_disp = 1'b0;
        in_ready  = 1'b0;
        case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_pend = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (wrap) begin
                    load_disp = 1'b1;
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // FSM state, staging/display registers, frame pulse and blanking copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            pend        <= '0;
            disp        <= '0;
            frame_start <= 1'b0;
            blank_q     <= 1'b0;
        end else begin
            state       <= state_d;
            frame_start <= wrap;
            blank_q     <= blank_lz;
            if (load_pend) pend <= in_data;
            if (load_disp) disp <= pend;
        end
    end

    // Display outputs depend on registered state only, so they hold steady
    // between ticks regardless of input activity.
    always_comb begin
        upper        = disp >> {idx, 2'b00};
        digit_sel    = ~(4'b0001 << idx);
        digit_nibble = disp[{idx, 2'b00} +: 4];
        digit_blank  = blank_q && (idx != 2'd0) && (upper == 16'h0000);
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver with PRESCALE=4: directed scenarios
// followed by randomized traffic, against a frame-level reference model.
module tb_hex_scan_driver;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        blank_lz;
    logic [3:0]  digit_nibble;
    logic [3:0]  digit_sel;
    logic        digit_blank;
    logic        frame_start;

    hex_scan_driver #(.PRESCALE(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .blank_lz     (blank_lz),
        .digit_nibble (digit_nibble),
        .digit_sel    (digit_sel),
        .digit_blank  (digit_blank),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: k counts clock edges since the reset edge.
    int          k;
    bit          m_full;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    bit          m_blank;
    bit          m_fs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    function automatic int m_idx();
        return (k / P) % 4;
    endfunction

    task automatic check_all();
        int          i;
        logic [15:0] shifted;
        i = m_idx();
        shifted = m_disp >> (4 * i);
        chk("in_ready",     in_ready,     !m_full);
        chk("digit_sel",    digit_sel,    4'hF ^ (4'h1 << i));
        chk("digit_nibble", digit_nibble, shifted & 16'hF);
        chk("digit_blank",  digit_blank,  m_blank && i != 0 && (32'(m_disp) < (32'h1 << (4 * i))));
        chk("frame_start",  frame_start,  m_fs);
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit bl, input bit r);
        rst_n    = r;
        in_valid = v;
        in_data  = d;
        blank_lz = bl;
        @(posedge clk);
        if (!r) begin
            k = 0; m_full = 0; m_pend = 0; m_disp = 0; m_blank = 0; m_fs = 0;
        end else begin
            bit wrap;
            k++;
            wrap = (k % (4 * P)) == 0;
            m_fs = wrap;
            if (m_full && wrap) begin
                m_disp = m_pend;
                m_full = 0;
            end else if (!m_full && v) begin
                m_pend = d;
                m_full = 1;
            end
            m_blank = bl;
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit bl);
        for (int i = 0; i < n; i++) step(0, 16'h0, bl, 1);
    endtask

    initial begin
        k = 0;
        step(0, 16'h0, 0, 0);
        step(0, 16'h0, 0, 0);
        chk("reset_sel",   digit_sel, 4'b1110);
        chk("reset_ready", in_ready,  1'b1);

        // Free-running scan over two frames.
        idle(32, 0);

        // Load 12AF, then offer BEEF while full.
        step(1, 16'h12AF, 0, 1);
        chk("ready_drop", in_ready, 1'b0);
        step(1, 16'hBEEF, 0, 1);
        while (m_full) step(1, 16'hBEEF, 0, 1);
        idle(16, 0);

        // Leading-zero blanking with 0005.
        while (k % (4 * P) != 0) idle(1, 1);
        step(1, 16'h0005, 1, 1);
        while (m_full) idle(1, 1);
        idle(16, 1);
        idle(16, 0);
        idle(16, 1);

        // Capture on the wrap edge itself.
        while ((k % (4 * P)) != (4 * P - 1)) idle(1, 0);
        step(1, 16'h3C00, 1, 1);
        idle(40, 1);

        // Reset while FULL at idx 2.
        step(1, 16'h7777, 0, 1);
        while (!(m_full && m_idx() == 2)) idle(1, 0);
        step(0, 16'h0, 0, 0);
        chk("midrst_sel",    digit_sel,    4'b1110);
        chk("midrst_ready",  in_ready,     1'b1);
        chk("midrst_nibble", digit_nibble, 4'h0);
        step(1, 16'hA5A5, 0, 1);
        chk("post_rst_accept", in_ready, 1'b0);
        idle(40, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) != 0);
            step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 1) == 1, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
